einsum_add_reduce_ctrl: RTL and testbench

Sequencer that reduces a variable-length stream of log-domain operands into a single log-sum-exp result by driving one shared `einsum_add` instance, one operand per cycle. It sits between an operand producer (a PE column or a buffer read port) and a result consumer. It owns the accumulator sequencing, the `bypass` and `enable` control, `pe_mode` latching and the result handshake. `einsum_add` is instantiated beside it and wired through the `add_*` ports.

---
 rtl/einsum_ctrl_pkg.sv | 17 +
 rtl/einsum_add_reduce_ctrl.sv | 99 +++++++++
 tb/tb_einsum_add_reduce_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/einsum_ctrl_pkg.sv
// Shared definitions for the einsum_add reduction controller.
//   state_e        : controller FSM states (IDLE, ACCUM, DONE)
//   PE_MODE_*      : pe_mode encodings understood by einsum_add
//   LSE_NEG_INF_24 : log-domain negative infinity in 24-bit mode
package einsum_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [1:0]  PE_MODE_24B    = 2'b00;
    localparam logic [1:0]  PE_MODE_6B     = 2'b01;
    localparam logic [31:0] LSE_NEG_INF_24 = 32'h0080_0000;

endpackage

// File: rtl/einsum_add_reduce_ctrl.sv
// Sequences a stream of log-domain operands through one shared einsum_add
// instance, one operand per cycle, and presents the log-sum-exp result.
// Ports:
//   clk, rst                   : clock, async active-high reset
//   cfg_mode                   : pe_mode, latched on the first accepted operand
//   in_valid/in_ready/in_data/in_last : operand stream
//   out_valid/out_ready/out_data/out_count : result handshake
//   busy                       : reduction in progress or result pending
//   add_*                      : control/data to einsum_add; add_sum is its
//                                registered sum_out (1-cycle latency)
module einsum_add_reduce_ctrl
    import einsum_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  busy,
    output logic                  add_enable,
    output logic                  add_bypass,
    output logic [WORD_WIDTH-1:0] add_operand_a,
    output logic [WORD_WIDTH-1:0] add_operand_b,
    output logic [1:0]            add_pe_mode,
    input  logic [WORD_WIDTH-1:0] add_sum
);

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 accept;
    logic                 is_idle;

    assign is_idle  = (state_q == ST_IDLE);
    assign in_ready = (state_q != ST_DONE);
    assign accept   = in_valid && in_ready;

    // First operand is loaded through bypass; later ones fold into add_sum,
    // which is already valid because each accept is a full cycle apart.
    assign add_enable    = accept;
    assign add_bypass    = accept && is_idle;
    assign add_operand_a = is_idle ? in_data : add_sum;
    assign add_operand_b = in_data;
    assign add_pe_mode   = is_idle ? cfg_mode : mode_q;

    // einsum_add holds its output while enable is low, so the result is
    // stable throughout DONE without a local copy.
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = add_sum;
    assign out_count = count_q;
    assign busy      = !is_idle;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mode_d  = cfg_mode;
                    count_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d = in_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (count_q != {CNT_WIDTH{1'b1}}) count_d = count_q + 1'b1;
                    if (in_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'b00;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_einsum_add_reduce_ctrl.sv
// Bench for einsum_add_reduce_ctrl. A stand-in einsum_add (registered,
// bypass loads operand_a, otherwise operand_a + operand_b) closes the loop;
// the reference result of each reduction is the plain wrap-around sum of its
// operands, and the count is the operand count clamped to the counter range.
module tb_einsum_add_reduce_ctrl;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg_mode = 2'b00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          busy;
    logic          add_enable;
    logic          add_bypass;
    logic [W-1:0]  add_operand_a;
    logic [W-1:0]  add_operand_b;
    logic [1:0]    add_pe_mode;
    logic [W-1:0]  add_sum = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    einsum_add_reduce_ctrl #(.WORD_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .busy(busy),
        .add_enable(add_enable), .add_bypass(add_bypass),
        .add_operand_a(add_operand_a), .add_operand_b(add_operand_b),
        .add_pe_mode(add_pe_mode), .add_sum(add_sum)
    );

    // stand-in for einsum_add
    always @(posedge clk)
        if (add_enable) add_sum <= add_bypass ? add_operand_a : add_operand_a + add_operand_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        else n_pass++;
    endtask

    // Runs one reduction; random gaps with gap_pct, plus gap_len forced idle
    // cycles before operand gap_at; result stalled for 'stall' cycles.
    task automatic run_red(input logic [31:0] ops[$], input logic [1:0] mode,
                           input int gap_pct, input int gap_at, input int gap_len,
                           input int stall);
        logic [31:0] exp_sum = '0;
        int k = 0;
        int forced = 0;
        int n = ops.size();
        int exp_cnt = (n > CNT_MAX) ? CNT_MAX : n;
        while (k < n) begin
            @(negedge clk);
            out_ready = 1'b0;
            if ((k == gap_at && forced < gap_len) ||
                (k > 0 && $urandom_range(99) < gap_pct)) begin
                if (k == gap_at) forced++;
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = $urandom_range(1);
                cfg_mode = 2'($urandom);
                #1;
                chk("gap_en", {31'b0, add_enable}, 32'd0);
                if (k > 0) begin
                    chk("gap_acc", add_sum, exp_sum);
                    chk("gap_mode", {30'b0, add_pe_mode}, {30'b0, mode});
                end
                continue;
            end
            in_valid = 1'b1;
            in_data  = ops[k];
            in_last  = (k == n - 1);
            cfg_mode = (k == 0) ? mode : 2'($urandom);
            #1;
            chk("in_ready", {31'b0, in_ready}, 32'd1);
            chk("acc_en", {31'b0, add_enable}, 32'd1);
            chk("bypass", {31'b0, add_bypass}, (k == 0) ? 32'd1 : 32'd0);
            chk("pe_mode", {30'b0, add_pe_mode}, {30'b0, mode});
            chk("op_b", add_operand_b, ops[k]);
            chk("op_a", add_operand_a, (k == 0) ? ops[0] : exp_sum);
            exp_sum = (k == 0) ? ops[0] : exp_sum + ops[k];
            k++;
        end
        // result must appear the cycle after the last accept and hold while stalled
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            in_valid  = $urandom_range(1);
            in_data   = $urandom;
            in_last   = $urandom_range(1);
            cfg_mode  = 2'($urandom);
            out_ready = (s == stall);
            #1;
            chk("out_valid", {31'b0, out_valid}, 32'd1);
            chk("out_data", out_data, exp_sum);
            chk("out_count", {28'b0, out_count}, 32'(exp_cnt));
            chk("done_rdy", {31'b0, in_ready}, 32'd0);
            chk("done_en", {31'b0, add_enable}, 32'd0);
            chk("done_busy", {31'b0, busy}, 32'd1);
            chk("done_mode", {30'b0, add_pe_mode}, {30'b0, mode});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("idle_ov", {31'b0, out_valid}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_rdy", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] q[$];
        int n;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ov", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_cnt", {28'b0, out_count}, 32'd0);
        chk("rst_en", {31'b0, add_enable}, 32'd0);
        chk("rst_byp", {31'b0, add_bypass}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdy", {31'b0, in_ready}, 32'd1);

        // single element
        q = '{32'hCAFE_BABE};
        run_red(q, 2'b00, 0, -1, 0, 0);
        // two elements
        q = '{32'h0010_0000, 32'h0020_0000};
        run_red(q, 2'b00, 0, -1, 0, 0);
        // 6-bit mode, cfg_mode scrambled after first accept
        q = '{32'h0001_2345, 32'h0054_3210};
        run_red(q, 2'b01, 0, -1, 0, 1);
        // 2-cycle gap mid-stream, 3-cycle stall
        q = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
        run_red(q, 2'b00, 0, 2, 2, 3);
        // NEG_INF operands pass through unmodified
        q = '{32'h0080_0000, 32'h0080_0000, 32'h0000_1000};
        run_red(q, 2'b00, 0, -1, 0, 0);
        // counter saturation
        q = {};
        for (int i = 0; i < CNT_MAX + 5; i++) q.push_back($urandom);
        run_red(q, 2'b01, 10, -1, 0, 1);

        // randomized reductions
        for (int r = 0; r < 12; r++) begin
            q = {};
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) q.push_back($urandom);
            run_red(q, 2'($urandom), 25, -1, 0, $urandom_range(0, 3));
        end

        // reset mid-stream after 2 of 4 operands
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h1111_1111; in_last = 1'b0; cfg_mode = 2'b01;
        @(negedge clk);
        in_data = 32'h2222_2222;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_ov", {31'b0, out_valid}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_cnt", {28'b0, out_count}, 32'd0);
        chk("mrst_en", {31'b0, add_enable}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_rdy", {31'b0, in_ready}, 32'd1);
        q = '{32'h0000_0000, 32'h0012_3456};
        run_red(q, 2'b00, 0, -1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
